dcb_config_loader: RTL and testbench
====================================

Name: dcb_config_loader

Overview:
Upstream configuration stage for the data connection block. It accepts a stream of narrow configuration words over a valid/ready handshake and assembles them into one CONF_WIDTH-bit frame. It drives the frame onto the connection block's `c` bus and then issues a single-cycle `cset` pulse so the connection block latches the whole frame at once. One loader sits beside each connection block tile.

Parameters:
- W, 16, fabric wires per side of the connection block
- DATAIN, 8, number of WW-bit MAC input lanes
- DATAOUT, 16, number of WW-bit MAC output lanes
- CONF_WIDTH, W*(DATAIN+DATAOUT), frame width (384 at defaults)
- IW, 8, width of one input config word; CONF_WIDTH must be a multiple of IW, otherwise elaboration fails via a generate-time check
- NWORDS (localparam), CONF_WIDTH/IW, words per frame (48 at defaults)
- CNT_W (localparam), $clog2(NWORDS), word counter width

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- cfg_start  input  1  begin (or restart) a frame
- cfg_data  input  IW  configuration word
- cfg_valid  input  1  cfg_data is valid
- cfg_ready  output  1  loader accepts a word this cycle
- c  output  CONF_WIDTH  assembled frame, goes to the connection block `c`
- cset  output  1  one-cycle commit strobe, goes to the connection block `cset`
- busy  output  1  a frame is in progress (state LOAD or COMMIT)
- loaded  output  1  sticky; at least one full frame has been committed since reset

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, counter=0
  - c=0, cset=0, busy=0, loaded=0
  - cfg_ready=0
- States: IDLE, LOAD, COMMIT. Encoding is a 2-bit enum.
- IDLE:
  - cfg_ready=0.
  - cfg_start=1 moves to LOAD on the next edge and clears the counter.
  - cfg_valid is ignored.
- LOAD:
  - cfg_ready = !cfg_start.
  - Handshake occurs when cfg_valid && cfg_ready.
  - On a handshake, c <= {cfg_data, c[CONF_WIDTH-1:IW]} (shift toward the LSB) and the counter increments.
  - After NWORDS handshakes, the first word sits in c[IW-1:0] and the last word in c[CONF_WIDTH-1 -: IW].
  - A handshake with counter == NWORDS-1 moves to COMMIT and resets the counter to 0.
  - cfg_start=1 in LOAD clears the counter and stays in LOAD. No word is accepted that cycle, because cfg_ready=0. Partial data is discarded logically: it is shifted out by the next full frame.
  - Idle cycles (cfg_valid=0) hold all state; there is no timeout.
- COMMIT (exactly one cycle):
  - cset=1, cfg_ready=0.
  - loaded <= 1 at the end of the cycle.
  - Next state is IDLE.
  - cfg_start is ignored in COMMIT. A new frame requires cfg_start while in IDLE.
- Output timing:
  - cset is a registered Moore output, high only in COMMIT.
  - c is stable during the cset cycle and holds until the next LOAD handshake.
  - Latency: last handshake in cycle N, cset high in cycle N+1, busy low from cycle N+2.
- busy = (state != IDLE).
- Reset asserted mid-LOAD or mid-COMMIT aborts immediately:
  - no cset pulse is produced;
  - c returns to 0, which leaves the connection block's own register unaffected (it only samples c on cset).
- The counter never exceeds NWORDS-1, and c never shifts outside LOAD.

Decomposition:
- Shared package dcb_pkg holds:
  - CONF_WIDTH computation as a function of W, DATAIN and DATAOUT, shared with the connection block;
  - state enum (IDLE, LOAD, COMMIT);
  - default IW.
- No sub-module is required; the shift register, counter and FSM live in one module.

Test Plan:
- Reset: hold rst for 3 cycles, release. Then c==0, cset==0, cfg_ready==0, busy==0, loaded==0.
- Full frame: cfg_start, then 48 back-to-back words with data=k (k=0..47). Then c[7:0]==8'h00, c[15:8]==8'h01, c[383:376]==8'h2F. cset is high exactly one cycle, one cycle after the 48th handshake. loaded==1 afterwards.
- Gaps and backpressure: the same frame with cfg_valid randomly low about 50% of the time. c is identical to the back-to-back case and there is still exactly one cset pulse.
- Restart:
  - cfg_start, 10 words of 8'hAA, then cfg_start asserted together with cfg_valid.
  - That cycle: no handshake (cfg_ready==0).
  - Then 48 words of 8'h55 produce c=={48{8'h55}} and a single cset pulse.
- Async reset mid-load: after 20 words, pulse rst for a fraction of a cycle. c==0 and busy==0 immediately, with no cset. A subsequent full frame commits correctly.
- Start in COMMIT: assert cfg_start during the cset cycle. The loader returns to IDLE (busy==0 next cycle) and cfg_ready stays 0 until a fresh cfg_start is seen in IDLE.

Source files
------------

// File: rtl/dcb_pkg.sv
// Shared definitions for the data connection block and its configuration loader.
//
// Contents:
//   conf_width()   - frame width of a connection block from its geometry
//   dcb_state_e    - configuration loader FSM states
//   IW_DEFAULT     - default width of one configuration word
package dcb_pkg;

    // Default width of a single configuration word on the loader input stream.
    localparam int unsigned IW_DEFAULT = 8;

    // One W-bit selection field per MAC lane, input lanes first then output lanes.
    function automatic int unsigned conf_width(input int unsigned w,
                                               input int unsigned datain,
                                               input int unsigned dataout);
        return w * (datain + dataout);
    endfunction

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLoad   = 2'd1,
        StCommit = 2'd2
    } dcb_state_e;

endpackage

// File: rtl/dcb_config_loader.sv
// Configuration loader for one data connection block tile.
//
// Collects NWORDS words of IW bits over a valid/ready stream, assembles them into a
// CONF_WIDTH-bit frame on c and then pulses cset for one cycle so the connection block
// captures the whole frame at once. Word 0 ends up in c[IW-1:0], the last word in the
// top IW bits of c.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   cfg_start  begin a frame (from idle) or restart the frame being loaded
//   cfg_data   configuration word
//   cfg_valid  cfg_data is valid
//   cfg_ready  a word is accepted this cycle (only while loading and not restarting)
//   c          assembled frame to the connection block
//   cset       one-cycle commit strobe to the connection block
//   busy       a frame is being loaded or committed
//   loaded     sticky: at least one frame committed since reset
module dcb_config_loader
    import dcb_pkg::*;
#(
    parameter int unsigned W          = 16,
    parameter int unsigned DATAIN     = 8,
    parameter int unsigned DATAOUT    = 16,
    parameter int unsigned CONF_WIDTH = conf_width(W, DATAIN, DATAOUT),
    parameter int unsigned IW         = IW_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic [IW-1:0]         cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic [CONF_WIDTH-1:0] c,
    output logic                  cset,
    output logic                  busy,
    output logic                  loaded
);

    localparam int unsigned NWORDS = CONF_WIDTH / IW;
    localparam int unsigned CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NWORDS - 1);

    // The frame must be an exact number of words.
    if ((CONF_WIDTH % IW) != 0) begin : g_width_check
        $error("dcb_config_loader: CONF_WIDTH must be a multiple of IW");
    end

    dcb_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CONF_WIDTH-1:0] c_q, c_d;
    logic                  loaded_q, loaded_d;

    // New word enters at the top, everything else moves one word toward the LSB.
    logic [CONF_WIDTH+IW-1:0] shift_in;
    assign shift_in = {cfg_data, c_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            c_q      <= '0;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            loaded_q <= loaded_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        c_d       = c_q;
        loaded_d  = loaded_q;
        cfg_ready = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cfg_start) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                end
            end

            StLoad: begin
                // A restart takes priority over any word presented the same cycle.
                cfg_ready = !cfg_start;
                if (cfg_start) begin
                    cnt_d = '0;
                end else if (cfg_valid) begin
                    c_d = shift_in[CONF_WIDTH+IW-1:IW];
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = StCommit;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            StCommit: begin
                // cfg_start is deliberately ignored here; a new frame starts from idle.
                loaded_d = 1'b1;
                state_d  = StIdle;
            end

            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // cset comes straight from the state register, so it is glitch-free for the
    // connection block and c is guaranteed stable while it is high.
    assign cset   = (state_q == StCommit);
    assign busy   = (state_q != StIdle);
    assign c      = c_q;
    assign loaded = loaded_q;

`ifndef SYNTHESIS
    a_cnt_bound: assert property (@(posedge clk) disable iff (rst) cnt_q <= CNT_LAST);
    a_cset_single: assert property (@(posedge clk) disable iff (rst) cset |=> !cset);
    a_c_only_in_load: assert property (@(posedge clk) disable iff (rst)
                                       (state_q != StLoad) |=> $stable(c_q));
`endif

endmodule

// File: tb/tb_dcb_config_loader.sv
// Self-checking bench for dcb_config_loader: a reference model predicts handshakes
// and completed frames; a separate monitor pops expected frames whenever cset fires.
module tb_dcb_config_loader;

    localparam int unsigned IW = 8;
    localparam int unsigned NW = 48;
    localparam int unsigned CW = 384;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_start = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [IW-1:0] cfg_data = '0;
    logic          cfg_ready;
    logic [CW-1:0] c;
    logic          cset;
    logic          busy;
    logic          loaded;

    dcb_config_loader #(
        .W          (16),
        .DATAIN     (8),
        .DATAOUT    (16),
        .CONF_WIDTH (CW),
        .IW         (IW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .c         (c),
        .cset      (cset),
        .busy      (busy),
        .loaded    (loaded)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: frames the model says must be committed, with the cycle of the strobe.
    typedef struct {
        logic [CW-1:0] frame;
        int            at;
    } exp_t;
    exp_t sb[$];

    // Reference model: a frame is simply the list of accepted words since the last start.
    logic          m_loading = 1'b0;
    logic          m_commit  = 1'b0;
    logic          m_loaded  = 1'b0;
    logic [IW-1:0] m_words[$];
    logic          m_c_known = 1'b1;
    logic [CW-1:0] m_c = '0;

    function automatic logic [CW-1:0] build_frame();
        logic [CW-1:0] f = '0;
        for (int k = 0; k < int'(NW); k++) f[k*IW +: IW] = m_words[k];
        return f;
    endfunction

    task automatic model_reset();
        m_loading = 1'b0;
        m_commit  = 1'b0;
        m_loaded  = 1'b0;
        m_words.delete();
        m_c_known = 1'b1;
        m_c       = '0;
    endtask

    // Drive one cycle: inputs applied after a rising edge, outputs checked on the falling
    // edge, model advanced after the next rising edge.
    task automatic drive(input logic st, input logic vl, input logic [IW-1:0] d);
        logic exp_ready;
        cfg_start = st;
        cfg_valid = vl;
        cfg_data  = d;
        exp_ready = m_loading && !st;
        @(negedge clk);
        chk("cfg_ready", CW'(cfg_ready), CW'(exp_ready));
        chk("busy", CW'(busy), CW'(m_loading || m_commit));
        chk("loaded", CW'(loaded), CW'(m_loaded));
        if (m_c_known) chk("c_hold", c, m_c);
        @(posedge clk);
        #1;
        if (m_commit) begin
            m_commit = 1'b0;
            m_loaded = 1'b1;
        end else if (!m_loading) begin
            if (st) begin
                m_loading = 1'b1;
                m_words.delete();
            end
        end else if (st) begin
            m_words.delete();
        end else if (vl) begin
            m_words.push_back(d);
            m_c_known = 1'b0;
            if (m_words.size() == NW) begin
                m_c       = build_frame();
                m_c_known = 1'b1;
                sb.push_back('{frame: m_c, at: edge_cnt});
                m_words.delete();
                m_loading = 1'b0;
                m_commit  = 1'b1;
            end
        end
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
    endtask

    // Monitor: every cset must match the oldest expected frame and arrive on time.
    always @(negedge clk) begin
        exp_t e;
        if (cset === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cset_unexpected: got cset=1 expected no commit (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                chk("frame", c, e.frame);
                chk("cset_cycle", CW'(edge_cnt), CW'(e.at));
            end
        end
    end

    task automatic send_frame_const(input logic [IW-1:0] d);
        for (int k = 0; k < int'(NW); k++) drive(1'b0, 1'b1, d);
    endtask

    initial begin
        logic [IW-1:0] rnd[NW];

        // Reset held for three cycles; outputs must already be cleared.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_c", c, '0);
        chk("rst_cset", CW'(cset), '0);
        chk("rst_ready", CW'(cfg_ready), '0);
        chk("rst_busy", CW'(busy), '0);
        chk("rst_loaded", CW'(loaded), '0);
        rst = 1'b0;
        model_reset();
        drive(1'b0, 1'b1, 8'hFF);  // valid in idle is ignored

        // Full frame back to back, word k = k.
        drive(1'b1, 1'b0, '0);
        for (int k = 0; k < int'(NW); k++) drive(1'b0, 1'b1, IW'(k));
        drive(1'b0, 1'b0, '0);  // commit cycle
        chk("byte0", CW'(c[7:0]), CW'(8'h00));
        chk("byte1", CW'(c[15:8]), CW'(8'h01));
        chk("byte47", CW'(c[383:376]), CW'(8'h2F));
        chk("loaded_after", CW'(loaded), CW'(1'b1));

        // Same frame with random gaps.
        drive(1'b1, 1'b0, '0);
        for (int k = 0; k < int'(NW); k++) begin
            while ($urandom_range(1, 0) == 0) drive(1'b0, 1'b0, IW'($urandom));
            drive(1'b0, 1'b1, IW'(k));
        end
        drive(1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, '0);

        // Restart mid-frame: start together with valid is not a handshake.
        drive(1'b1, 1'b0, '0);
        for (int k = 0; k < 10; k++) drive(1'b0, 1'b1, 8'hAA);
        drive(1'b1, 1'b1, 8'hAA);
        send_frame_const(8'h55);
        drive(1'b0, 1'b0, '0);
        chk("restart_c", c, {48{8'h55}});

        // Asynchronous reset mid-load.
        drive(1'b1, 1'b0, '0);
        for (int k = 0; k < 20; k++) drive(1'b0, 1'b1, IW'($urandom));
        #2 rst = 1'b1;
        #1;
        chk("arst_c", c, '0);
        chk("arst_busy", CW'(busy), '0);
        chk("arst_cset", CW'(cset), '0);
        #1 rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        for (int k = 0; k < int'(NW); k++) rnd[k] = IW'($urandom);
        drive(1'b1, 1'b0, '0);
        for (int k = 0; k < int'(NW); k++) drive(1'b0, 1'b1, rnd[k]);
        drive(1'b0, 1'b0, '0);

        // Start during the commit cycle is ignored.
        drive(1'b1, 1'b0, '0);
        for (int k = 0; k < int'(NW); k++) drive(1'b0, 1'b1, IW'($urandom));
        drive(1'b1, 1'b0, '0);        // commit cycle with start high
        drive(1'b0, 1'b1, 8'h12);     // idle: no ready, no busy
        drive(1'b0, 1'b1, 8'h34);
        drive(1'b1, 1'b1, 8'h56);     // fresh start from idle
        for (int k = 0; k < int'(NW); k++) drive(1'b0, 1'b1, IW'($urandom));
        drive(1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, '0);

        chk("sb_empty", CW'(sb.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard bound on run time.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
